// File: rtl/sub16_serial.sv
// Serial subtractor: z = x - y computed SLICE bits per clock, LSB slice first,
// with borrow-as-inverted-carry chained between slices and adder-style flags.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepted edge
// RUN   | one slice of x + ~y + c per cycle; results loaded on the last slice
// DONE  | done pulse for one cycle, then back to IDLE
module sub16_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             borrow,
  output logic             parity,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] xr, yr, acc, acc_nx;
  logic [CW-1:0]    cnt;
  logic             c;
  logic [SLICE-1:0] xs, ys;
  logic [SLICE:0]   sum;

  // acc fills from the top, so after N shifts slice 0 sits at the bottom
  always_comb begin
    xs     = xr[cnt*SLICE +: SLICE];
    ys     = yr[cnt*SLICE +: SLICE];
    sum    = {1'b0, xs} + {1'b0, ~ys} + {{SLICE{1'b0}}, c};
    acc_nx = (acc >> SLICE) | (WIDTH'(sum[SLICE-1:0]) << (WIDTH - SLICE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      xr       <= '0;
      yr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      z        <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      borrow   <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xr    <= x;
            yr    <= y;
            acc   <= '0;
            c     <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nx;
          c   <= sum[SLICE];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            done     <= 1'b1;
            z        <= acc_nx;
            sign     <= acc_nx[WIDTH-1];
            zero     <= (acc_nx == '0);
            borrow   <= ~sum[SLICE];
            parity   <= ~^acc_nx;
            overflow <= (xr[WIDTH-1] != yr[WIDTH-1]) && (acc_nx[WIDTH-1] != xr[WIDTH-1]);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub16_serial.sv
// Directed bench for sub16_serial: latency, flags, busy-start rejection, reset abort.
module tb_sub16_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x, y;
  logic [15:0] z;
  logic        sign, zero, borrow, parity, overflow, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  sub16_serial dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .z(z),
    .sign(sign), .zero(zero), .borrow(borrow), .parity(parity),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, " z"}, 32'(z), 32'h0);
    chk({tag, " flags"}, {27'b0, sign, zero, borrow, parity, overflow}, 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " done"}, 32'(done), 32'h0);
  endtask

  // One full operation; zp is the result that must stay on z until completion.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ez, input logic es, input logic ezr,
                       input logic eb, input logic ep, input logic eo,
                       input logic [15:0] zp);
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    @(negedge clk);               // edge E has passed
    start = 1'b0; x = ~a; y = a ^ b;
    for (int k = 0; k < 4; k++) begin
      chk({tag, " run busy"}, 32'(busy), 32'h1);
      chk({tag, " run done"}, 32'(done), 32'h0);
      chk({tag, " run z held"}, 32'(z), 32'(zp));
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 32'h1);
    chk({tag, " busy@done"}, 32'(busy), 32'h1);
    chk({tag, " z"}, 32'(z), 32'(ez));
    chk({tag, " sign"}, 32'(sign), 32'(es));
    chk({tag, " zero"}, 32'(zero), 32'(ezr));
    chk({tag, " borrow"}, 32'(borrow), 32'(eb));
    chk({tag, " parity"}, 32'(parity), 32'(ep));
    chk({tag, " overflow"}, 32'(overflow), 32'(eo));
    @(negedge clk);
    chk({tag, " done cleared"}, 32'(done), 32'h0);
    chk({tag, " busy cleared"}, 32'(busy), 32'h0);
    chk({tag, " z hold"}, 32'(z), 32'(ez));
  endtask

  int dcount;
  int gap;

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    chk_zero_outs("reset");

    // reset wins over start in the same cycle
    start = 1'b1; x = 16'h0005; y = 16'h0003;
    @(negedge clk);
    chk("rst prio busy", 32'(busy), 32'h0);
    start = 1'b0; rst = 1'b0;

    do_op("5-3",      16'h0005, 16'h0003, 16'h0002, 0, 0, 0, 0, 0, 16'h0000);
    do_op("3-5",      16'h0003, 16'h0005, 16'hFFFE, 1, 0, 1, 0, 0, 16'h0002);
    do_op("7FFF-FFFF",16'h7FFF, 16'hFFFF, 16'h8000, 1, 0, 1, 0, 1, 16'hFFFE);
    do_op("8000-1",   16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 0, 1, 16'h8000);
    do_op("eq",       16'h1234, 16'h1234, 16'h0000, 0, 1, 0, 1, 0, 16'h7FFF);

    // start while busy is ignored
    @(negedge clk);
    x = 16'h0010; y = 16'h0001; start = 1'b1;
    @(negedge clk);               // after E
    start = 1'b0;
    @(negedge clk);               // after E+1; next edge is E+2
    x = 16'hFFFF; y = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        dcount++;
        chk("busy-start z", 32'(z), 32'h000F);
        chk("busy-start parity", 32'(parity), 32'h1);
        chk("busy-start busy@done", 32'(busy), 32'h1);
      end
      @(negedge clk);
    end
    chk("busy-start done count", 32'(dcount), 32'h1);

    // reset in the middle of RUN aborts without a done
    x = 16'h0005; y = 16'h0003; start = 1'b1;
    @(negedge clk);               // after E
    start = 1'b0;
    @(negedge clk);               // after E+1
    rst = 1'b1;
    @(negedge clk);               // after E+2
    chk_zero_outs("mid reset");
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("mid reset no done", 32'(dcount), 32'h0);
    do_op("after rst", 16'h0100, 16'h0001, 16'h00FF, 0, 0, 0, 1, 0, 16'h0000);

    // start held high: accepted every 6 cycles
    x = 16'h0005; y = 16'h0003; start = 1'b1;
    gap = 0;
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    chk("hold first done", 32'(done), 32'h1);
    @(negedge clk);
    gap = 1;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("hold done period", 32'(gap), 32'd6);
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sub16_serial.md
# sub16_serial

Multi-cycle 16-bit subtractor computing z = x − y one 4-bit slice per clock, least-significant slice first, with a borrow chained between slices. It produces the same status flags as the team's combinational 16-bit adder: sign, zero, parity and overflow, with borrow in place of carry. It is the inverse arithmetic unit in the datapath, for area-constrained paths that can tolerate a multi-cycle latency. A start/busy/done handshake lets a controller sequence it.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; latency scales as WIDTH/SLICE.

- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  WIDTH  minuend; captured on the accepted start edge.
- y  input  WIDTH  subtrahend; captured on the accepted start edge.
- z  output  WIDTH  registered difference x − y, modulo 2^WIDTH.
- sign  output  1  z[WIDTH-1].
- zero  output  1  1 when z == 0.
- borrow  output  1  1 when x < y, unsigned; equals the inverted final carry-out.
- parity  output  1  even parity: XNOR-reduce of z, so 1 when z has an even number of ones.
- overflow  output  1  signed overflow: (x[MSB] != y[MSB]) and (z[MSB] != x[MSB]).
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse when the result and flags become valid.

## Operation
- Arithmetic: x + ~y + 1. Carry register c is initialised to 1 at start.
- Per RUN cycle k (k = 0..WIDTH/SLICE−1), on slice k:
  - {c, acc[k]} ← xr[k] + ~yr[k] + c.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch x and y into xr and yr, set c=1, cnt=0, and go to RUN.
  - On start=0, stay in IDLE.
- RUN:
  - Process one slice per cycle and increment cnt.
  - After the last slice (cnt == WIDTH/SLICE−1), go to DONE.
  - On that same edge, load z ← full acc and all flags, computed from the final acc, c, xr and yr.
- DONE:
  - done=1 for exactly one cycle, then unconditionally return to IDLE.
- z and the flags change only on the completion edge and hold until the next completion or reset. Intermediate slices are never visible on z.
- start while busy (RUN or DONE) is ignored. Operands are not re-captured and the in-flight result is unaffected.
- Changes on x and y after capture have no effect.

## Timing
- Reset (rst=1 at a rising edge):
  - state=IDLE.
  - z=0, sign=0, zero=0, borrow=0, parity=0, overflow=0, busy=0, done=0.
  - Flags reset to 0 regardless of z; they are meaningful only after the first done.
- Reset mid-operation aborts the subtraction. No done is issued, and the outputs take their reset values on that edge.
- Reset has priority over start in the same cycle.
- Latency with default parameters:
  - start sampled at edge E.
  - RUN slices are processed on edges E+1 through E+4.
  - Results are registered on edge E+4; done=1 and results are valid during the cycle after E+4.
- busy is 1 from after edge E through the done cycle, and 0 after edge E+5.
- Throughput: one subtraction per WIDTH/SLICE+2 cycles. The earliest next accepted start is at edge E+6, and start held high continuously is accepted every 6 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- x=0x0005, y=0x0003, start at E:
  - done only in the cycle after E+4.
  - z=0x0002, sign=0, zero=0, borrow=0, parity=0, overflow=0.
- x=0x0003, y=0x0005:
  - z=0xFFFE, sign=1, borrow=1, parity=0, overflow=0, zero=0.
- x=0x7FFF, y=0xFFFF:
  - z=0x8000, overflow=1, sign=1, borrow=1, parity=0.
- x=0x8000, y=0x0001:
  - z=0x7FFF, overflow=1, sign=0, borrow=0, parity=0.
- x=0x1234, y=0x1234:
  - z=0x0000, zero=1, parity=1, borrow=0, overflow=0.
- Start 0x0010−0x0001, then pulse start at E+2 with x=0xFFFF, y=0xFFFF:
  - the second start is ignored and exactly one done occurs, with z=0x000F.
  - busy stays 1 through the done cycle.
- rst=1 at E+2 during RUN:
  - all outputs 0 and no done pulse.
  - a following start of 0x0100−0x0001 completes normally with z=0x00FF, parity=1.
